// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone B4 classic arbiter with round-robin grant
// and a strobe watchdog that returns err to the owner on a stalled slave.
module wb_arbiter2 #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_sel,
    input  logic            m0_we,
    input  logic            m0_cyc,
    input  logic            m0_stb,
    output logic [DW-1:0]   m0_rdata,
    output logic            m0_ack,
    output logic            m0_err,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_sel,
    input  logic            m1_we,
    input  logic            m1_cyc,
    input  logic            m1_stb,
    output logic [DW-1:0]   m1_rdata,
    output logic            m1_ack,
    output logic            m1_err,
    output logic [AW-1:0]   s_addr,
    output logic [DW-1:0]   s_wdata,
    output logic [DW/8-1:0] s_sel,
    output logic            s_we,
    output logic            s_cyc,
    output logic            s_stb,
    input  logic [DW-1:0]   s_rdata,
    input  logic            s_ack,
    output logic [1:0]      grant
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } own_e;

    own_e          state_q;
    logic          last_q;
    logic [CW-1:0] cnt_q;

    logic own_cyc;
    logic own_stb;
    logic rearb;
    logic timeout;

    always_comb begin
        own_cyc  = 1'b0;
        own_stb  = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_sel    = '0;
        s_we     = 1'b0;
        unique case (state_q)
            OWN0: begin
                own_cyc = m0_cyc;
                own_stb = m0_stb;
                s_addr  = m0_addr;
                s_wdata = m0_wdata;
                s_sel   = m0_sel;
                s_we    = m0_we;
            end
            OWN1: begin
                own_cyc = m1_cyc;
                own_stb = m1_stb;
                s_addr  = m1_addr;
                s_wdata = m1_wdata;
                s_sel   = m1_sel;
                s_we    = m1_we;
            end
            default: ;
        endcase
    end

    // Ack wins over a timeout landing in the same cycle.
    assign timeout = own_cyc & own_stb & ~s_ack
                   & (cnt_q == CW'(TIMEOUT - 1));
    assign rearb   = (state_q == IDLE) | ~own_cyc;

    assign s_cyc    = own_cyc;
    assign s_stb    = own_cyc & own_stb & ~timeout;
    assign grant    = state_q;
    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;
    assign m0_ack   = (state_q == OWN0) & own_cyc & s_ack;
    assign m1_ack   = (state_q == OWN1) & own_cyc & s_ack;
    assign m0_err   = (state_q == OWN0) & timeout;
    assign m1_err   = (state_q == OWN1) & timeout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            if (rearb) begin
                if (m0_cyc && m1_cyc) begin
                    state_q <= last_q ? OWN0 : OWN1;
                    last_q  <= ~last_q;
                end else if (m0_cyc) begin
                    state_q <= OWN0;
                end else if (m1_cyc) begin
                    state_q <= OWN1;
                end else begin
                    state_q <= IDLE;
                end
            end
            // An owner change implies the old owner's cyc is low, so
            // the strobe term below also covers that clear.
            if (!(own_cyc && own_stb) || s_ack || timeout) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule
